// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one RAM port between instruction fetch and data access.
//             A registered FSM grants one requester at a time and steers the
//             address, data and strobes to the RAM. The data side has
//             priority. A starvation counter forces a fetch grant after
//             STARVE_LIMIT back-to-back data grants while a fetch is pending.
//             A per-service cycle counter raises a sticky timeout flag.
//  Ports    : CLK, nRST (sync, active-low)
//             iREN/iaddr -> iload/iwait       instruction side
//             dREN/dWEN/daddr/dstore -> dload/dwait   data side
//             ramREN/ramWEN/ramaddr/ramstore, ramload/ramready  RAM port
//             tmo_err   sticky service-timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 63
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        tmo_err
);

    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int SVC_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0]  C_STARVE_LIMIT = SC_W'(STARVE_LIMIT);
    localparam logic [SVC_W-1:0] C_TIMEOUT      = SVC_W'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISERV = 2'd1;
    localparam logic [1:0] DSERV = 2'd2;

    logic [1:0]       r_state;
    logic [SC_W-1:0]  r_starve_cnt;
    logic [SVC_W-1:0] r_svc_cnt;
    logic             r_tmo_err;

    logic             w_dreq;
    logic             w_i_done;
    logic             w_d_done;
    logic [SC_W-1:0]  w_starve_next;
    logic [1:0]       w_grant;
    logic [1:0]       w_state_next;
    logic [SVC_W-1:0] w_svc_next;

    // Next-state logic. The grant decision uses the starvation count as it
    // will be after this cycle, so the completion that reaches the limit is
    // the one that hands the port to the fetch side.
    always_comb begin
        w_dreq   = dREN | dWEN;
        w_i_done = (r_state == ISERV) && ramready && iREN;
        w_d_done = (r_state == DSERV) && ramready && w_dreq;

        w_starve_next = r_starve_cnt;
        if (!iREN || w_i_done) begin
            w_starve_next = '0;
        end else if (w_d_done && (r_starve_cnt < C_STARVE_LIMIT)) begin
            w_starve_next = r_starve_cnt + 1'b1;
        end

        if (w_dreq && ((w_starve_next < C_STARVE_LIMIT) || !iREN)) begin
            w_grant = DSERV;
        end else if (iREN) begin
            w_grant = ISERV;
        end else begin
            w_grant = IDLE;
        end

        // A dropped request (abort) or a completion both release the port.
        case (r_state)
            ISERV:   w_state_next = (!iREN || ramready) ? w_grant : ISERV;
            DSERV:   w_state_next = (!w_dreq || ramready) ? w_grant : DSERV;
            default: w_state_next = w_grant;
        endcase

        if ((r_state == IDLE) || (w_state_next != r_state) || w_i_done || w_d_done) begin
            w_svc_next = '0;
        end else if (r_svc_cnt < C_TIMEOUT) begin
            w_svc_next = r_svc_cnt + 1'b1;
        end else begin
            w_svc_next = r_svc_cnt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_svc_cnt    <= '0;
            r_tmo_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_svc_cnt    <= w_svc_next;
            // The FSM keeps waiting after a timeout; only the flag records it.
            r_tmo_err    <= r_tmo_err | (w_svc_next == C_TIMEOUT);
        end
    end

    // RAM steering. Strobes follow the live request so an abort drops them
    // in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            ISERV: begin
                ramREN  = iREN;
                ramaddr = iaddr;
            end
            DSERV: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iwait   = iREN & ~((r_state == ISERV) & ramready);
    assign dwait   = w_dreq & ~((r_state == DSERV) & ramready);
    assign iload   = ramload;
    assign dload   = ramload;
    assign tmo_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: directed scenarios for
//             reset, fetch latency, priority, starvation, write-wins, abort
//             and timeout, plus randomized traffic against a port-ownership
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, tmo_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(63)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready),
        .tmo_err(tmo_err)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nRST = 0;
        step();
        step();
        nRST = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        iREN = 1; dREN = 1;
        step();
        settle();
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, tmo_err} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got ren=%b wen=%b addr=%h err=%b, want all 0",
                     ramREN, ramWEN, ramaddr, tmo_err);
        end
        step();
        nRST = 1;
    endtask

    task automatic test_fetch_latency();
        int low_cycles = 0;
        apply_reset();
        iREN = 1; iaddr = 32'h0; ramready = 0;
        settle();
        n_cmp++;
        if (ramREN !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_idle: got ren=%b iwait=%b, want ren=0 iwait=1", ramREN, iwait);
        end
        step();
        settle();
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_grant: got ren=%b addr=%h iwait=%b, want 1/0/1", ramREN, ramaddr, iwait);
        end
        // Two cycles of service, ready on the second.
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                ramready = 1; ramload = 32'h1234_5678;
            end
            settle();
            if (iwait === 1'b0) low_cycles++;
            if (k == 1) begin
                n_cmp++;
                if (iload !== 32'h1234_5678) begin
                    n_err++;
                    $display("FAIL fetch_iload: got %h want 12345678", iload);
                end
            end
            if (k == 0) step();
        end
        n_cmp++;
        if (low_cycles != 1) begin
            n_err++;
            $display("FAIL fetch_iwait_low: got %0d cycles want 1", low_cycles);
        end
        iREN = 0; ramready = 0;
        step();
    endtask

    task automatic test_priority();
        apply_reset();
        iREN = 1; dREN = 1; iaddr = 32'hA0; daddr = 32'hB0; ramready = 0;
        step();
        settle();
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'hB0 || dwait !== 1'b1 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL priority_data_first: got ren=%b addr=%h, want ren=1 addr=b0", ramREN, ramaddr);
        end
        ramready = 1;
        settle();
        n_cmp++;
        if (dwait !== 1'b0 || iwait !== 1'b1) begin
            n_err++;
            $display("FAIL priority_complete: got dwait=%b iwait=%b want 0/1", dwait, iwait);
        end
        step();
        // Data request withdrawn: fetch takes the port with no idle bubble.
        dREN = 0; ramready = 0;
        step();
        settle();
        n_cmp++;
        if (ramREN !== 1'b1 || ramaddr !== 32'hA0) begin
            n_err++;
            $display("FAIL priority_fetch_next: got ren=%b addr=%h want 1/a0", ramREN, ramaddr);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_starvation();
        int exp_owner [8] = '{2, 2, 2, 1, 2, 2, 2, 1};
        apply_reset();
        dWEN = 1; iREN = 1; daddr = 32'h100; iaddr = 32'h200; ramready = 1;
        step();
        for (int k = 0; k < 8; k++) begin
            settle();
            n_cmp++;
            if (ramWEN !== (exp_owner[k] == 2) || ramREN !== (exp_owner[k] == 1) ||
                dwait !== (exp_owner[k] != 2) || iwait !== (exp_owner[k] != 1)) begin
                n_err++;
                $display("FAIL starve_seq[%0d]: got wen=%b ren=%b dwait=%b iwait=%b, want owner %0d",
                         k, ramWEN, ramREN, dwait, iwait, exp_owner[k]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_write_wins();
        apply_reset();
        dREN = 1; dWEN = 1; daddr = 32'h40; dstore = 32'hDEAD_BEEF;
        step();
        settle();
        n_cmp++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h40) begin
            n_err++;
            $display("FAIL write_wins: got wen=%b ren=%b store=%h addr=%h want 1/0/deadbeef/40",
                     ramWEN, ramREN, ramstore, ramaddr);
        end
        ramready = 1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_fetch_abort();
        apply_reset();
        iREN = 1; iaddr = 32'h300; ramready = 0;
        step();
        settle();
        n_cmp++;
        if (ramREN !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: got ren=%b want 1", ramREN);
        end
        step();
        iREN = 0;
        settle();
        n_cmp++;
        if (ramREN !== 1'b0 || iwait !== 1'b0) begin
            n_err++;
            $display("FAIL abort_same_cycle: got ren=%b iwait=%b want 0/0", ramREN, iwait);
        end
        step();
        settle();
        n_cmp++;
        if (ramaddr !== 32'h0 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got addr=%h ren=%b wen=%b want idle zeros", ramaddr, ramREN, ramWEN);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        dREN = 1; daddr = 32'h80; ramready = 0;
        step();
        for (int k = 1; k <= 62; k++) step();
        settle();
        n_cmp++;
        if (tmo_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got %b after 62 cycles want 0", tmo_err);
        end
        step();
        settle();
        n_cmp++;
        if (tmo_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set: got %b after 63 cycles want 1", tmo_err);
        end
        for (int k = 0; k < 5; k++) step();
        settle();
        n_cmp++;
        if (tmo_err !== 1'b1 || ramREN !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: got err=%b ren=%b want 1/1", tmo_err, ramREN);
        end
        nRST = 0;
        step();
        settle();
        n_cmp++;
        if (tmo_err !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_reset: got err=%b ren=%b addr=%h want 0/0/0", tmo_err, ramREN, ramaddr);
        end
        nRST = 1;
        idle_inputs();
        step();
    endtask

    // Reference model: tracks which side owns the RAM port (0 none,
    // 1 fetch, 2 data) and applies the arbitration rules at each edge.
    task automatic test_random();
        int  own, starve, stall, pick, nxt;
        bit  err, dreq, fin, released;
        logic [31:0] e_addr, e_store;
        logic        e_ren, e_wen, e_iwait, e_dwait;
        apply_reset();
        own = 0; starve = 0; stall = 0; err = 0;
        for (int c = 0; c < 500; c++) begin
            iREN     = ($urandom_range(3) != 0);
            dREN     = $urandom_range(1);
            dWEN     = ($urandom_range(3) == 0);
            ramready = ($urandom_range(2) == 0);
            iaddr    = $urandom; daddr = $urandom;
            dstore   = $urandom; ramload = $urandom;
            dreq     = dREN | dWEN;

            e_ren   = (own == 1) ? iREN : (own == 2) ? (dREN & ~dWEN) : 1'b0;
            e_wen   = (own == 2) ? dWEN : 1'b0;
            e_addr  = (own == 1) ? iaddr : (own == 2) ? daddr : 32'h0;
            e_store = (own == 2) ? dstore : 32'h0;
            e_iwait = iREN & ~((own == 1) & ramready);
            e_dwait = dreq & ~((own == 2) & ramready);

            settle();
            n_cmp++;
            if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin
                n_err++;
                $display("FAIL rnd_strobe[%0d]: got ren=%b wen=%b want %b/%b", c, ramREN, ramWEN, e_ren, e_wen);
            end
            n_cmp++;
            if (ramaddr !== e_addr || ramstore !== e_store) begin
                n_err++;
                $display("FAIL rnd_addr[%0d]: got %h/%h want %h/%h", c, ramaddr, ramstore, e_addr, e_store);
            end
            n_cmp++;
            if (iwait !== e_iwait || dwait !== e_dwait) begin
                n_err++;
                $display("FAIL rnd_wait[%0d]: got i=%b d=%b want %b/%b", c, iwait, dwait, e_iwait, e_dwait);
            end
            n_cmp++;
            if (iload !== ramload || dload !== ramload || tmo_err !== err) begin
                n_err++;
                $display("FAIL rnd_load_err[%0d]: got %h/%h err=%b want %h err=%b",
                         c, iload, dload, tmo_err, ramload, err);
            end

            fin = ((own == 1) && iREN && ramready) || ((own == 2) && dreq && ramready);
            if (!iREN || ((own == 1) && fin)) starve = 0;
            else if ((own == 2) && fin && starve < 3) starve++;
            pick = (dreq && (starve < 3 || !iREN)) ? 2 : (iREN ? 1 : 0);
            released = (own == 0) || fin || ((own == 1) && !iREN) || ((own == 2) && !dreq);
            nxt = released ? pick : own;
            if (nxt != 0 && nxt == own && !fin) stall = (stall < 63) ? stall + 1 : 63;
            else stall = 0;
            if (stall == 63) err = 1;
            own = nxt;
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        test_reset();
        test_fetch_latency();
        test_priority();
        test_starvation();
        test_write_wins();
        test_fetch_abort();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
